// File: rtl/usb3_rx_if.sv
// FT601 245-synchronous FIFO receive path: bursts OE/RD reads into a skid buffer that drains into the dc32 FIFO.
// Optional USB3_RX_WORD_COUNT_EN adds a free-running 32-bit count of words written to the dc32 FIFO.
module usb3_rx_if #(
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 256,
   parameter int SKID_DEPTH = 4,
   localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
   input  logic                  ftdi_clk,
   input  logic                  reset_n,
   input  logic                  FR_RXF,
   output logic                  FT_OE,
   output logic                  FT_RD,
   input  logic [DATA_WIDTH-1:0] usb3_data_in,
   input  logic [BE_WIDTH-1:0]   usb3_be_in,
   output logic                  write_to_dc32_fifo,
   output logic [DATA_WIDTH-1:0] dc32_fifo_data_in,
   input  logic                  dc32_fifo_almost_full,
   input  logic                  dc32_fifo_is_empty,
   output logic                  if_idle,
`ifdef USB3_RX_WORD_COUNT_EN
   output logic [31:0]           rx_word_count,
`endif
   output logic                  short_word_seen,
   output logic                  overflow_err
);

   localparam int PTR_W   = $clog2(SKID_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int BURST_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0]   SKID_FULL = CNT_W'(SKID_DEPTH);
   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

   typedef enum logic [2:0] {
      IDLE,
      OE_TA,
      READ,
      RELEASE,
      COOL
   } state_t;

   state_t state;
   state_t state_next;

   logic [DATA_WIDTH-1:0] skid_mem [SKID_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      skid_count;
   logic [CNT_W-1:0]      count_next;
   logic [BURST_W-1:0]    burst_count;
   logic [BURST_W-1:0]    burst_next;
   logic [BURST_W-1:0]    burst_plus;

   logic capture;
   logic be_all_zero;
   logic be_full;
   logic push_req;
   logic push;
   logic pop;
   logic drop;
   logic skid_full;
   logic burst_limit;
   logic oe_next;
   logic rd_next;
   logic if_idle_next;

   // A word is on the bus whenever RD is already low and the FT601 still reports data.
   assign capture     = (state == READ) && !FT_RD && !FR_RXF;
   assign be_all_zero = (usb3_be_in == '0);
   assign be_full     = &usb3_be_in;
   assign push_req    = capture && !be_all_zero;
   assign skid_full   = (skid_count == SKID_FULL);
   assign pop         = (skid_count != '0) && !dc32_fifo_almost_full;
   assign push        = push_req && (!skid_full || pop);
   assign drop        = push_req && skid_full && !pop;
   assign count_next  = skid_count + CNT_W'(push) - CNT_W'(pop);
   assign burst_plus  = burst_count + BURST_W'(1);
   assign burst_limit = capture && (burst_plus == BURST_MAX);

   always_ff @(posedge ftdi_clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Leaving READ is decided at the capture edge itself so RD rises before the skid can overrun.
   always_comb begin
      state_next   = state;
      burst_next   = burst_count;
      oe_next      = 1'b1;
      rd_next      = 1'b1;
      if_idle_next = 1'b0;
      case (state)
         IDLE: begin
            if (!FR_RXF && !dc32_fifo_almost_full && (skid_count == '0)) begin
               state_next = OE_TA;
            end
         end
         OE_TA: begin
            state_next = READ;
         end
         READ: begin
            if (capture) begin
               burst_next = burst_plus;
            end
            if (FR_RXF || dc32_fifo_almost_full || burst_limit || (count_next == SKID_FULL)) begin
               state_next = RELEASE;
            end
         end
         RELEASE: begin
            state_next = COOL;
         end
         COOL: begin
            burst_next = '0;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      oe_next      = !((state_next == OE_TA) || (state_next == READ) || (state_next == RELEASE));
      rd_next      = (state_next != READ);
      if_idle_next = (state_next == IDLE) && (count_next == '0) && dc32_fifo_is_empty;
   end

   always_ff @(posedge ftdi_clk or negedge reset_n) begin
      if (!reset_n) begin
         FT_OE           <= 1'b1;
         FT_RD           <= 1'b1;
         if_idle         <= 1'b1;
         burst_count     <= '0;
         short_word_seen <= 1'b0;
         overflow_err    <= 1'b0;
      end else begin
         FT_OE       <= oe_next;
         FT_RD       <= rd_next;
         if_idle     <= if_idle_next;
         burst_count <= burst_next;
         if (push && !be_full) begin
            short_word_seen <= 1'b1;
         end
         if (drop) begin
            overflow_err <= 1'b1;
         end
      end
   end

   // Storage is unreset; only the pointers and count define what is valid.
   always_ff @(posedge ftdi_clk) begin
      if (push) begin
         skid_mem[wr_ptr] <= usb3_data_in;
      end
   end

   always_ff @(posedge ftdi_clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         skid_count         <= '0;
         write_to_dc32_fifo <= 1'b0;
         dc32_fifo_data_in  <= '0;
      end else begin
         skid_count <= count_next;
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr             <= rd_ptr + PTR_W'(1);
            write_to_dc32_fifo <= 1'b1;
            dc32_fifo_data_in  <= skid_mem[rd_ptr];
         end else begin
            write_to_dc32_fifo <= 1'b0;
         end
      end
   end

`ifdef USB3_RX_WORD_COUNT_EN
   always_ff @(posedge ftdi_clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_word_count <= '0;
      end else if (pop) begin
         rx_word_count <= rx_word_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_usb3_rx_if.sv
// Randomised bench for usb3_rx_if: an FT601 device model feeds words, a scoreboard checks order, count and handshake rules.
module tb_usb3_rx_if;

   localparam int DW = 32;
   localparam int BW = 4;
   localparam int MB = 4;
   localparam int SD = 4;

   logic          ftdi_clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          FR_RXF = 1'b1;
   logic          FT_OE;
   logic          FT_RD;
   logic [DW-1:0] usb3_data_in = '0;
   logic [BW-1:0] usb3_be_in = '0;
   logic          write_to_dc32_fifo;
   logic [DW-1:0] dc32_fifo_data_in;
   logic          dc32_fifo_almost_full = 1'b0;
   logic          dc32_fifo_is_empty = 1'b1;
   logic          if_idle;
   logic          short_word_seen;
   logic          overflow_err;
`ifdef USB3_RX_WORD_COUNT_EN
   logic [31:0]   rx_word_count;
`endif

   usb3_rx_if #(
      .DATA_WIDTH(DW),
      .MAX_BURST(MB),
      .SKID_DEPTH(SD)
   ) dut (
      .ftdi_clk(ftdi_clk),
      .reset_n(reset_n),
      .FR_RXF(FR_RXF),
      .FT_OE(FT_OE),
      .FT_RD(FT_RD),
      .usb3_data_in(usb3_data_in),
      .usb3_be_in(usb3_be_in),
      .write_to_dc32_fifo(write_to_dc32_fifo),
      .dc32_fifo_data_in(dc32_fifo_data_in),
      .dc32_fifo_almost_full(dc32_fifo_almost_full),
      .dc32_fifo_is_empty(dc32_fifo_is_empty),
      .if_idle(if_idle),
`ifdef USB3_RX_WORD_COUNT_EN
      .rx_word_count(rx_word_count),
`endif
      .short_word_seen(short_word_seen),
      .overflow_err(overflow_err)
   );

   always #5 ftdi_clk = ~ftdi_clk;

   typedef struct {
      logic [DW-1:0] data;
      logic [BW-1:0] be;
   } word_t;

   word_t         dev_q[$];
   logic [DW-1:0] exp_q[$];
   int            burst_q[$];

   int   total_checks = 0;
   int   pass_checks = 0;
   int   capture_total = 0;
   int   write_total = 0;
   int   wc_model = 0;
   logic model_short = 1'b0;

   logic          e_rxf = 1'b1;
   logic          e_af = 1'b0;
   logic          e_rst = 1'b0;
   logic [DW-1:0] e_data = '0;
   logic [BW-1:0] e_be = '0;

   logic last_rd = 1'b1;
   logic last_oe = 1'b1;
   int   oe_high_run = 2;
   int   oe_lead = 0;
   int   cur_burst = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total_checks++;
      if (observed === expected) begin
         pass_checks++;
      end else begin
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [DW-1:0] data, input logic [BW-1:0] be);
      word_t w;
      w.data = data;
      w.be   = be;
      dev_q.push_back(w);
   endtask

   task automatic checkBursts(input int n, input int lens[3]);
      checkOutput("burst_number", 32'(burst_q.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (i < burst_q.size()) begin
            checkOutput("burst_len", 32'(burst_q[i]), 32'(lens[i]));
         end
      end
   endtask

   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      while (((dev_q.size() != 0) || (exp_q.size() != 0)) && (n < budget)) begin
         @(negedge ftdi_clk);
         n++;
      end
      checkOutput("drain_left", 32'(dev_q.size() + exp_q.size()), 32'd0);
      repeat (6) @(negedge ftdi_clk);
      checkOutput("if_idle_end", 32'(if_idle), 32'd1);
      checkOutput("overflow_end", 32'(overflow_err), 32'd0);
   endtask

   // Inputs are stable across the rising edge, so sample what the DUT saw there.
   initial begin
      forever begin
         @(posedge ftdi_clk);
         e_rxf  = FR_RXF;
         e_af   = dc32_fifo_almost_full;
         e_rst  = reset_n;
         e_data = usb3_data_in;
         e_be   = usb3_be_in;
      end
   end

   // FT601 device model and scoreboard: each handshake edge consumes the head word.
   initial begin
      forever begin
         @(negedge ftdi_clk);
         if (!reset_n || !e_rst) begin
            exp_q.delete();
            last_rd     = 1'b1;
            last_oe     = 1'b1;
            oe_high_run = 2;
            oe_lead     = 0;
            cur_burst   = 0;
            model_short = 1'b0;
            wc_model    = 0;
         end else begin
            if (!last_rd && !e_rxf) begin
               if (dev_q.size() > 0) begin
                  void'(dev_q.pop_front());
               end
               cur_burst++;
               capture_total++;
               if (e_be != '0) begin
                  exp_q.push_back(e_data);
                  if (e_be != 4'hF) begin
                     model_short = 1'b1;
                  end
               end
               if (cur_burst == MB) begin
                  checkOutput("rd_release_limit", 32'(FT_RD), 32'd1);
               end
            end
            if (!last_rd && (e_af || e_rxf)) begin
               checkOutput("rd_release", 32'(FT_RD), 32'd1);
            end
            if (write_to_dc32_fifo) begin
               write_total++;
               wc_model++;
               checkOutput("write_under_af", 32'(e_af), 32'd0);
               if (exp_q.size() == 0) begin
                  checkOutput("unexpected_write", 32'd1, 32'd0);
               end else begin
                  checkOutput("write_data", dc32_fifo_data_in, exp_q.pop_front());
               end
            end
            if (last_rd && !FT_RD) begin
               checkOutput("oe_lead_cycles", 32'(oe_lead), 32'd1);
            end
            if (!last_rd && FT_RD) begin
               burst_q.push_back(cur_burst);
               checkOutput("burst_le_max", 32'(cur_burst <= MB), 32'd1);
               cur_burst = 0;
            end
            if (last_oe && !FT_OE) begin
               checkOutput("oe_gap", 32'(oe_high_run >= 2), 32'd1);
            end
            oe_high_run = FT_OE ? oe_high_run + 1 : 0;
            oe_lead     = (!FT_OE && FT_RD) ? oe_lead + 1 : 0;
            last_rd     = FT_RD;
            last_oe     = FT_OE;
         end
         if (dev_q.size() > 0) begin
            FR_RXF       = 1'b0;
            usb3_data_in = dev_q[0].data;
            usb3_be_in   = dev_q[0].be;
         end else begin
            FR_RXF       = 1'b1;
            usb3_data_in = $urandom();
            usb3_be_in   = 4'($urandom_range(0, 15));
         end
      end
   end

   initial begin
      int w0;
      int c0;
      int n;
      int sent;
      int r;
      logic [BW-1:0] be;

      // Reset with data pending on the FT601 side.
      reset_n = 1'b0;
      dc32_fifo_is_empty = 1'b1;
      applyStimulus(32'hDEAD0000, 4'hF);
      repeat (3) @(negedge ftdi_clk);
      checkOutput("rst_oe", 32'(FT_OE), 32'd1);
      checkOutput("rst_rd", 32'(FT_RD), 32'd1);
      checkOutput("rst_write", 32'(write_to_dc32_fifo), 32'd0);
      checkOutput("rst_data", dc32_fifo_data_in, 32'd0);
      checkOutput("rst_if_idle", 32'(if_idle), 32'd1);
      checkOutput("rst_short", 32'(short_word_seen), 32'd0);
      checkOutput("rst_overflow", 32'(overflow_err), 32'd0);
      dev_q.delete();
      repeat (2) @(negedge ftdi_clk);
      reset_n = 1'b1;
      repeat (3) @(negedge ftdi_clk);
      checkOutput("idle_after_rst", 32'(if_idle), 32'd1);
      dc32_fifo_is_empty = 1'b0;
      repeat (2) @(negedge ftdi_clk);
      checkOutput("idle_fifo_busy", 32'(if_idle), 32'd0);
      dc32_fifo_is_empty = 1'b1;

      // Eight words, split into bursts of MB.
      burst_q.delete();
      w0 = write_total;
      for (int i = 1; i <= 8; i++) applyStimulus(32'(i), 4'hF);
      waitDrain(300);
      checkOutput("single_writes", 32'(write_total - w0), 32'd8);
      checkBursts(2, '{4, 4, 0});

      // Ten words: bursts 4, 4, 2.
      burst_q.delete();
      w0 = write_total;
      for (int i = 0; i < 10; i++) applyStimulus(32'h100 + 32'(i), 4'hF);
      waitDrain(300);
      checkOutput("limit_writes", 32'(write_total - w0), 32'd10);
      checkBursts(3, '{4, 4, 2});

      // Almost-full raised after the third capture, held 20 cycles.
      w0 = write_total;
      c0 = capture_total;
      for (int i = 0; i < 8; i++) applyStimulus(32'hA000 + 32'(i), 4'hF);
      n = 0;
      while ((capture_total - c0 < 3) && (n < 100)) begin
         @(negedge ftdi_clk);
         n++;
      end
      checkOutput("bp_third_capture", 32'(capture_total - c0 >= 3), 32'd1);
      dc32_fifo_almost_full = 1'b1;
      repeat (20) @(negedge ftdi_clk);
      dc32_fifo_almost_full = 1'b0;
      waitDrain(300);
      checkOutput("bp_writes", 32'(write_total - w0), 32'd8);

      // Byte enables: empty word dropped, partial word flagged.
      w0 = write_total;
      applyStimulus(32'h11111111, 4'h0);
      applyStimulus(32'h22222222, 4'h3);
      applyStimulus(32'h33333333, 4'hF);
      waitDrain(200);
      checkOutput("be_writes", 32'(write_total - w0), 32'd2);
      checkOutput("be_short_seen", 32'(short_word_seen), 32'd1);
      repeat (5) @(negedge ftdi_clk);
      checkOutput("be_short_sticky", 32'(short_word_seen), 32'd1);

      // Reset in the middle of a read burst.
      for (int i = 0; i < 40; i++) applyStimulus(32'hB000 + 32'(i), 4'hF);
      n = 0;
      while (FT_RD && (n < 100)) begin
         @(negedge ftdi_clk);
         n++;
      end
      checkOutput("mid_rd_low", 32'(FT_RD), 32'd0);
      #2;
      reset_n = 1'b0;
      dev_q.delete();
      #1;
      checkOutput("mid_rst_oe", 32'(FT_OE), 32'd1);
      checkOutput("mid_rst_rd", 32'(FT_RD), 32'd1);
      checkOutput("mid_rst_write", 32'(write_to_dc32_fifo), 32'd0);
      repeat (2) @(negedge ftdi_clk);
      reset_n = 1'b1;
      w0 = write_total;
      repeat (20) @(negedge ftdi_clk);
      checkOutput("no_write_after_rst", 32'(write_total - w0), 32'd0);
      checkOutput("short_cleared", 32'(short_word_seen), 32'd0);
      for (int i = 0; i < 3; i++) applyStimulus(32'hC000 + 32'(i), 4'hF);
      waitDrain(200);
      checkOutput("post_rst_writes", 32'(write_total - w0), 32'd3);

      // Random soak: bursty arrivals, mixed byte enables, toggling back-pressure.
      sent = 0;
      n = 0;
      while ((sent < 120) && (n < 4000)) begin
         @(negedge ftdi_clk);
         n++;
         if ($urandom_range(0, 3) == 0) begin
            for (int k = $urandom_range(1, 6); k > 0; k--) begin
               r = $urandom_range(0, 19);
               be = (r < 3) ? 4'h0 : (r < 7) ? 4'($urandom_range(1, 14)) : 4'hF;
               applyStimulus($urandom(), be);
               sent++;
            end
         end
         if ($urandom_range(0, 7) == 0) dc32_fifo_almost_full = ~dc32_fifo_almost_full;
      end
      dc32_fifo_almost_full = 1'b0;
      waitDrain(3000);
      checkOutput("soak_short", 32'(short_word_seen), 32'(model_short));
`ifdef USB3_RX_WORD_COUNT_EN
      checkOutput("rx_word_count", rx_word_count, 32'(wc_model));
`endif

      $display("%0d/%0d checks passed", pass_checks, total_checks);
      $finish;
   end

endmodule

// File: doc/usb3_rx_if.md
Name: usb3_rx_if

Overview:
- Parametrised successor to the FT601 receive path: drives the FTDI 245-synchronous FIFO read handshake in bursts and forwards received words into the dc32 clock-crossing FIFO.
- Adds the following over the fixed 32-bit path:
  - configurable data width;
  - byte-enable handling;
  - a bounded burst length;
  - an internal skid buffer, so almost-full back-pressure never loses a word.
- Sits between the FT601 pins and the dc32 FIFO write side, entirely in the ftdi_clk domain.

Parameters:
DATA_WIDTH, 32, width of the FTDI data bus and the FIFO word (16 or 32)
BE_WIDTH, DATA_WIDTH/8, derived localparam, byte-enable width
MAX_BURST, 256, maximum words read per OE/RD burst before a forced turnaround (>=1)
SKID_DEPTH, 4, skid buffer entries (power of 2, >=2)

Ports:
ftdi_clk  in  1  FT601 clock; all logic is on the rising edge
reset_n  in  1  asynchronous active-low reset
FR_RXF  in  1  active low; FT601 has receive data
FT_OE  out  1  active low; FT601 drives the data bus
FT_RD  out  1  active low; read strobe
usb3_data_in  in  DATA_WIDTH  FT601 data bus
usb3_be_in  in  BE_WIDTH  FT601 byte enables, qualified with data
write_to_dc32_fifo  out  1  write strobe to the dc32 FIFO
dc32_fifo_data_in  out  DATA_WIDTH  word to the dc32 FIFO
dc32_fifo_almost_full  in  1  dc32 FIFO almost full; guarantees >=1 free entry after assertion
dc32_fifo_is_empty  in  1  dc32 FIFO empty
if_idle  out  1  high when state IDLE, skid empty and dc32_fifo_is_empty are all true
short_word_seen  out  1  sticky; a partial byte-enable word was forwarded
overflow_err  out  1  sticky; a capture was attempted with the skid full (design error)
rx_word_count  out  32  only with USB3_RX_WORD_COUNT_EN

Behaviour:
- Reset values (asynchronous, immediate on reset_n low):
  - FT_OE=1, FT_RD=1, write_to_dc32_fifo=0, dc32_fifo_data_in=0;
  - short_word_seen=0, overflow_err=0, skid empty, burst count 0, state IDLE.
  - Reset asserted mid-burst releases OE/RD without waiting for a clock edge.
- All outputs are registered.
- FSM states and transitions:
  - IDLE -> OE_TA: when FR_RXF=0, dc32_fifo_almost_full=0 and the skid is empty.
  - OE_TA: FT_OE=0, FT_RD=1 for exactly one cycle (bus turnaround), then -> READ.
  - READ: FT_OE=0, FT_RD=0.
    - Capture at an edge where the registered FT_RD=0 and the sampled FR_RXF=0.
    - Each capture increments the burst count.
    - Leave READ at that edge if any of these hold (FT_RD=1 after that edge): FR_RXF=1; dc32_fifo_almost_full=1; burst count reaches MAX_BURST; this capture fills the skid.
    - A capture at the same edge that RD deasserts is kept.
  - RELEASE: FT_RD=1, FT_OE=0 for one cycle, then -> COOL.
  - COOL: FT_OE=1 for one cycle, burst count cleared, then -> IDLE. Minimum OE-high gap between bursts is 2 cycles.
- Byte enables:
  - usb3_be_in all zero: word discarded; not counted toward the skid, but counted toward the burst.
  - Partial (not all ones): word forwarded unchanged and short_word_seen set.
- Skid output:
  - At each edge, if the skid is non-empty and almost_full=0, write=1, dc32_fifo_data_in=head, and the head is popped; otherwise write=0 and data holds.
  - Capture-to-write latency is one cycle minimum.
  - Order is strictly preserved.
  - Simultaneous push and pop at a full skid is legal.
- overflow_err: a push to a full skid that is not popped at the same edge drops the word and sets overflow_err. Unreachable in a correct design; asserted in verification.
- Widths: DATA_WIDTH=16 uses BE_WIDTH=2; no packing or unpacking is performed.

Optional Feature:
- Macro: USB3_RX_WORD_COUNT_EN.
- Defined: adds a 32-bit rx_word_count output.
  - Increments on every write_to_dc32_fifo cycle.
  - Wraps 0xFFFFFFFF -> 0.
  - Resets to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset_n=0 with FR_RXF=0 -> FT_OE=FT_RD=1, write=0, data=0, if_idle=1 after release with dc32_fifo_is_empty=1.
- Single burst: 8 words 0x1..0x8 with BE=0xF -> OE low 1 cycle before RD, exactly 8 writes in order, OE high >=2 cycles after, returns to IDLE.
- Burst limit: MAX_BURST=4, 10 words available -> three bursts (4,4,2) with RD high between; 10 writes in order; overflow_err=0.
- Back-pressure: almost_full=1 after the 3rd word for 20 cycles -> RD high at the next edge, no writes during almost_full, no loss; remaining words follow in order after release.
- Byte enables: words BE=0x0, 0x3, 0xF -> 2 writes (BE 0x3 word then 0xF word); short_word_seen=1 stays set.
- Reset mid-READ: reset_n low while RD=0 -> FT_OE/FT_RD high with no clock edge; skid flushed; no write after release until new data arrives.
